// File: rtl/imc_wb_loader.sv
// Wishbone-classic slave that pushes host words into the IM / IB write FIFOs and holds the
// PC run control. Optional macro IMC_WB_ERR_EN: error-out pushes to a full FIFO instead of stalling.
module imc_wb_loader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_SIZE = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [3:0]           wb_adr_i,
    input  logic [DATA_W-1:0]    wb_dat_i,
    output logic [DATA_W-1:0]    wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 im_wr_cs,
    output logic                 im_wr_en,
    output logic [ADDR_SIZE-1:0] im_wr_addr,
    output logic [DATA_W-1:0]    im_wr_data,
    input  logic                 im_full,
    input  logic                 im_empty,
    output logic                 ib_wr_cs,
    output logic                 ib_wr_en,
    output logic [ADDR_SIZE-1:0] ib_wr_addr,
    output logic [DATA_W-1:0]    ib_wr_data,
    input  logic                 ib_full,
    input  logic                 ib_empty,
    output logic                 enable_PC_IM,
    output logic [ADDR_SIZE-1:0] start_PC_IM_address
);

    typedef enum logic [1:0] {IDLE, PUSH, WAIT, ACK} state_t;

    localparam logic [3:0] ADR_IM     = 4'd0;
    localparam logic [3:0] ADR_IB     = 4'd1;
    localparam logic [3:0] ADR_CTRL   = 4'd2;
    localparam logic [3:0] ADR_STATUS = 4'd3;

    state_t               r_state;
    state_t               w_next_state;
    logic [3:0]           r_adr;
    logic                 r_we;
    logic                 r_tgt_ib;
    logic                 r_err;
    logic [DATA_W-1:0]    r_data;
    logic [ADDR_SIZE-1:0] r_im_ptr;
    logic [ADDR_SIZE-1:0] r_ib_ptr;
    logic                 r_enable;
    logic [ADDR_SIZE-1:0] r_start;

    logic                 w_req;
    logic                 w_push_req;
    logic                 w_req_full;
    logic                 w_tgt_full;
    logic                 w_req_err;
    logic                 w_ctrl_wr;
    logic                 w_clr_wr;
    logic [DATA_W-1:0]    w_rdata;

    assign w_req      = wb_cyc_i & wb_stb_i;
    assign w_push_req = w_req & wb_we_i & ((wb_adr_i == ADR_IM) | (wb_adr_i == ADR_IB));
    assign w_req_full = (wb_adr_i == ADR_IB) ? ib_full : im_full;
    assign w_tgt_full = r_tgt_ib ? ib_full : im_full;
    assign w_ctrl_wr  = (r_state == IDLE) & w_req & wb_we_i & (wb_adr_i == ADR_CTRL);
    assign w_clr_wr   = (r_state == IDLE) & w_req & wb_we_i & (wb_adr_i == ADR_STATUS) & wb_dat_i[0];

`ifdef IMC_WB_ERR_EN
    assign w_req_err = w_push_req & w_req_full;
`else
    assign w_req_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_push_req) begin
                    if (!w_req_full) w_next_state = PUSH;
`ifdef IMC_WB_ERR_EN
                    else             w_next_state = ACK;
`else
                    else             w_next_state = WAIT;
`endif
                end else if (w_req) begin
                    w_next_state = ACK;
                end
            end
            PUSH: w_next_state = ACK;
            WAIT: begin
                // The host abandoned the cycle: drop the push silently.
                if (!wb_cyc_i)        w_next_state = IDLE;
                else if (!w_tgt_full) w_next_state = PUSH;
            end
            ACK:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adr    <= '0;
            r_we     <= 1'b0;
            r_tgt_ib <= 1'b0;
            r_err    <= 1'b0;
            r_data   <= '0;
            r_im_ptr <= '0;
            r_ib_ptr <= '0;
            r_enable <= 1'b0;
            r_start  <= '0;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_adr    <= wb_adr_i;
                r_we     <= wb_we_i;
                r_tgt_ib <= (wb_adr_i == ADR_IB);
                r_err    <= w_req_err;
                r_data   <= wb_dat_i;
            end
            if (w_ctrl_wr) begin
                r_enable <= wb_dat_i[0];
                r_start  <= wb_dat_i[8 +: ADDR_SIZE];
            end
            // Pointers wrap naturally at 2**ADDR_SIZE.
            if (w_clr_wr) begin
                r_im_ptr <= '0;
                r_ib_ptr <= '0;
            end else if (r_state == PUSH) begin
                if (r_tgt_ib) r_ib_ptr <= r_ib_ptr + ADDR_SIZE'(1);
                else          r_im_ptr <= r_im_ptr + ADDR_SIZE'(1);
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_rdata = '0;
        case (r_adr)
            ADR_CTRL: begin
                w_rdata[0]              = r_enable;
                w_rdata[8 +: ADDR_SIZE] = r_start;
            end
            ADR_STATUS: begin
                w_rdata[3:0]             = {ib_full, ib_empty, im_full, im_empty};
                w_rdata[8 +: ADDR_SIZE]  = r_im_ptr;
                w_rdata[24 +: ADDR_SIZE] = r_ib_ptr;
            end
            default: ;
        endcase
    end

    always_comb begin
        wb_ack_o   = 1'b0;
        wb_err_o   = 1'b0;
        wb_dat_o   = '0;
        im_wr_cs   = 1'b0;
        im_wr_en   = 1'b0;
        im_wr_addr = '0;
        im_wr_data = '0;
        ib_wr_cs   = 1'b0;
        ib_wr_en   = 1'b0;
        ib_wr_addr = '0;
        ib_wr_data = '0;
        case (r_state)
            PUSH: begin
                if (r_tgt_ib) begin
                    ib_wr_cs   = 1'b1;
                    ib_wr_en   = 1'b1;
                    ib_wr_addr = r_ib_ptr;
                    ib_wr_data = r_data;
                end else begin
                    im_wr_cs   = 1'b1;
                    im_wr_en   = 1'b1;
                    im_wr_addr = r_im_ptr;
                    im_wr_data = r_data;
                end
            end
            ACK: begin
                if (r_err) begin
                    wb_err_o = 1'b1;
                end else begin
                    wb_ack_o = 1'b1;
                    if (!r_we) wb_dat_o = w_rdata;
                end
            end
            default: ;
        endcase
    end

    assign enable_PC_IM        = r_enable;
    assign start_PC_IM_address = r_start;

endmodule
